pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
//  Per-register freeze/flush controls: PC, IF/ID, ID/EXE, EXE/MEM, MEM/WB.
//  Detects data hazards and taken branches. Stalls the pipe for multi-cycle data-memory accesses using a wait-state FSM.
//  Keeps a saturating stall-cycle counter for performance measurement.
// PARAMETERS
//  WAIT_CYCLES  4   stall cycles per data-memory access (0 = single-cycle memory, no stall)
//  FORWARD_EN   1   1: forwarding unit present, only load-use hazards stall; 0: stall on any RAW hazard
//  CNT_W        32  width of stall_count
// PORTS
//  clk            in   1      clock, rising edge
//  rst            in   1      synchronous reset, active-high
//  ID_src1        in   5      source reg 1 of instruction in ID
//  ID_src2        in   5      source reg 2 of instruction in ID
//  ID_two_src     in   1      ID instruction reads ID_src2
//  EXE_dest       in   5      dest reg of instruction in EXE
//  EXE_WB_En      in   1      EXE instruction writes back
//  EXE_MEM_R_En   in   1      EXE instruction is a load
//  Br_taken       in   1      branch resolved taken in EXE
//  MEM_dest       in   5      dest reg of instruction in MEM (EXE/MEM register output)
//  MEM_WB_En      in   1      MEM instruction writes back
//  MEM_R_En       in   1      MEM instruction reads data memory
//  MEM_W_En       in   1      MEM instruction writes data memory
//  freeze_PC      out  1      PC holds value
//  freeze_IF_ID   out  1      IF/ID register holds
//  flush_IF_ID    out  1      IF/ID loads NOP (all zero) at next edge
//  freeze_ID_EXE  out  1      ID/EXE register holds
//  flush_ID_EXE   out  1      ID/EXE loads bubble (all enables 0)
//  freeze_EXE_MEM out  1      EXE/MEM register holds
//  flush_MEM_WB   out  1      MEM/WB loads bubble (WB_En 0)
//  mem_busy       out  1      data-memory access in progress, pipe stalled
//  mem_done       out  1      1-cycle pulse: access completes this cycle
//  stall_count    out  CNT_W  cycles with freeze_PC=1; saturates at all-ones
// BEHAVIOUR
//  - Reset: FSM=IDLE, wait counter=0, stall_count=0; all control outputs 0 while rst=1.
//  - mem_req = MEM_R_En | MEM_W_En.
//  - FSM IDLE:
//    - mem_req & WAIT_CYCLES>0 -> stall_all=1; go WAIT with cnt=WAIT_CYCLES-1.
//    - mem_req & WAIT_CYCLES=0 -> mem_done=1, no stall.
//  - FSM WAIT:
//    - cnt!=0 -> stall_all=1, cnt--.
//    - cnt==0 -> stall_all=0, mem_done=1, go IDLE.
//    - Total stall = WAIT_CYCLES cycles per access.
//    - Back-to-back accesses restart from IDLE on the next cycle.
//  - mem_busy = stall_all. Combinational outputs from state + inputs; no output latency.
//  - Hazard (src!=0 only; reg 0 never hazards; src2 compared only if ID_two_src):
//    - FORWARD_EN=1: EXE_MEM_R_En & EXE_WB_En & EXE_dest==src.
//    - FORWARD_EN=0: (EXE_WB_En & EXE_dest==src) | (MEM_WB_En & MEM_dest==src).
//  - Priority, highest first; exactly one row applies:
//    - stall_all: freeze_PC, freeze_IF_ID, freeze_ID_EXE, freeze_EXE_MEM=1; flush_MEM_WB=1.
//      Branch and hazard are ignored; held inputs re-evaluate after release.
//    - Br_taken: flush_IF_ID=1, flush_ID_EXE=1; no freezes (wrong-path ID instruction discarded, even if hazarding).
//    - hazard: freeze_PC, freeze_IF_ID=1, flush_ID_EXE=1.
//    - else: all 0.
//  - freeze_X and flush_X are never both 1 for the same register.
//  - stall_count increments on each cycle with freeze_PC=1 (mem or hazard); holds at 2^CNT_W-1.
//  - Reset mid-WAIT: next cycle IDLE, cnt=0, all outputs 0, stall_count=0.
// TESTING
//  - WAIT_CYCLES=4, MEM_R_En=1 held -> mem_busy/freezes/flush_MEM_WB=1 for 4 cycles; mem_done=1 on 5th; stall_count=4.
//  - EXE_MEM_R_En=1, EXE_WB_En=1, EXE_dest=5, ID_src1=5 -> freeze_PC=freeze_IF_ID=flush_ID_EXE=1 same cycle; EXE_dest=0 -> all 0.
//  - ID_two_src=0, ID_src2=5, EXE load dest 5 -> no hazard; ID_two_src=1 -> hazard.
//  - Load-use hazard and Br_taken=1 together -> flush_IF_ID=flush_ID_EXE=1, freeze_PC=0; stall_count unchanged.
//  - rst=1 in 2nd WAIT cycle -> next cycle all outputs 0, stall_count=0; MEM_W_En=1 afterwards restarts a full 4-cycle stall.
//  - WAIT_CYCLES=0, MEM_W_En=1 three consecutive cycles -> mem_done=1 each cycle, no freeze; FORWARD_EN=0 with MEM_WB_En=1, MEM_dest=ID_src1=7 -> hazard.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for a 5-stage pipe with a data-memory wait-state FSM
module pipeline_hazard_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int FORWARD_EN  = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_src1,
  input  logic [4:0]       ID_src2,
  input  logic             ID_two_src,
  input  logic [4:0]       EXE_dest,
  input  logic             EXE_WB_En,
  input  logic             EXE_MEM_R_En,
  input  logic             Br_taken,
  input  logic [4:0]       MEM_dest,
  input  logic             MEM_WB_En,
  input  logic             MEM_R_En,
  input  logic             MEM_W_En,
  output logic             freeze_PC,
  output logic             freeze_IF_ID,
  output logic             flush_IF_ID,
  output logic             freeze_ID_EXE,
  output logic             flush_ID_EXE,
  output logic             freeze_EXE_MEM,
  output logic             flush_MEM_WB,
  output logic             mem_busy,
  output logic             mem_done,
  output logic [CNT_W-1:0] stall_count
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = WAIT_CYCLES > 0 ? CW'(WAIT_CYCLES - 1) : '0;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_stall_count;
  logic w_mem_req, w_stall, w_done, w_hz1, w_hz2, w_hazard, w_st, w_br, w_hz;
  assign w_mem_req = MEM_R_En | MEM_W_En;
  // With forwarding only a load in EXE cannot be bypassed in time
  assign w_hz1 = (ID_src1 != 5'd0) & ((FORWARD_EN != 0)
               ? (EXE_MEM_R_En & EXE_WB_En & (EXE_dest == ID_src1))
               : ((EXE_WB_En & (EXE_dest == ID_src1)) | (MEM_WB_En & (MEM_dest == ID_src1))));
  assign w_hz2 = ID_two_src & (ID_src2 != 5'd0) & ((FORWARD_EN != 0)
               ? (EXE_MEM_R_En & EXE_WB_En & (EXE_dest == ID_src2))
               : ((EXE_WB_En & (EXE_dest == ID_src2)) | (MEM_WB_En & (MEM_dest == ID_src2))));
  assign w_hazard = w_hz1 | w_hz2;
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_stall    = 1'b0;
    w_done     = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_mem_req) begin
        if (WAIT_CYCLES > 0) begin
          w_stall    = 1'b1;
          w_next     = S_WAIT;
          w_cnt_next = LOAD;
        end else begin
          w_done = 1'b1;
        end
      end
    end else if (r_cnt != '0) begin
      w_stall    = 1'b1;
      w_cnt_next = r_cnt - CW'(1);
    end else begin
      w_done = 1'b1;
      w_next = S_IDLE;
    end
  end
  assign w_st = ~rst & w_stall;
  assign w_br = ~rst & ~w_stall & Br_taken;
  assign w_hz = ~rst & ~w_stall & ~Br_taken & w_hazard;
  assign freeze_PC      = w_st | w_hz;
  assign freeze_IF_ID   = w_st | w_hz;
  assign flush_IF_ID    = w_br;
  assign freeze_ID_EXE  = w_st;
  assign flush_ID_EXE   = w_br | w_hz;
  assign freeze_EXE_MEM = w_st;
  assign flush_MEM_WB   = w_st;
  assign mem_busy       = w_st;
  assign mem_done       = ~rst & w_done;
  assign stall_count    = r_stall_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (freeze_PC && !(&r_stall_count)) r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for two parameterisations of pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] ID_src1 = '0, ID_src2 = '0, EXE_dest = '0, MEM_dest = '0;
  logic ID_two_src = 0, EXE_WB_En = 0, EXE_MEM_R_En = 0, Br_taken = 0;
  logic MEM_WB_En = 0, MEM_R_En = 0, MEM_W_En = 0;
  logic [8:0] c0, c1;
  logic [31:0] n0, n1;
  int errors = 0, checks = 0;
  // bit order: freeze_PC, freeze_IF_ID, flush_IF_ID, freeze_ID_EXE, flush_ID_EXE, freeze_EXE_MEM, flush_MEM_WB, mem_busy, mem_done
  localparam logic [8:0] Z  = 9'b000000000;
  localparam logic [8:0] ST = 9'b110101110;
  localparam logic [8:0] DN = 9'b000000001;
  localparam logic [8:0] BR = 9'b001010000;
  localparam logic [8:0] HZ = 9'b110010000;
  typedef struct packed {logic d; logic [8:0] ctl; logic [31:0] cnt;} exp_t;
  exp_t  exp_q[$];
  string name_q[$];
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.WAIT_CYCLES(4), .FORWARD_EN(1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
    .EXE_dest(EXE_dest), .EXE_WB_En(EXE_WB_En), .EXE_MEM_R_En(EXE_MEM_R_En), .Br_taken(Br_taken),
    .MEM_dest(MEM_dest), .MEM_WB_En(MEM_WB_En), .MEM_R_En(MEM_R_En), .MEM_W_En(MEM_W_En),
    .freeze_PC(c0[8]), .freeze_IF_ID(c0[7]), .flush_IF_ID(c0[6]), .freeze_ID_EXE(c0[5]),
    .flush_ID_EXE(c0[4]), .freeze_EXE_MEM(c0[3]), .flush_MEM_WB(c0[2]), .mem_busy(c0[1]),
    .mem_done(c0[0]), .stall_count(n0));
  pipeline_hazard_ctrl #(.WAIT_CYCLES(0), .FORWARD_EN(0), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_two_src(ID_two_src),
    .EXE_dest(EXE_dest), .EXE_WB_En(EXE_WB_En), .EXE_MEM_R_En(EXE_MEM_R_En), .Br_taken(Br_taken),
    .MEM_dest(MEM_dest), .MEM_WB_En(MEM_WB_En), .MEM_R_En(MEM_R_En), .MEM_W_En(MEM_W_En),
    .freeze_PC(c1[8]), .freeze_IF_ID(c1[7]), .flush_IF_ID(c1[6]), .freeze_ID_EXE(c1[5]),
    .flush_ID_EXE(c1[4]), .freeze_EXE_MEM(c1[3]), .flush_MEM_WB(c1[2]), .mem_busy(c1[1]),
    .mem_done(c1[0]), .stall_count(n1));
  task automatic chk(input logic d, input logic [8:0] ctl, input logic [31:0] cnt, input string nm);
    exp_q.push_back('{d: d, ctl: ctl, cnt: cnt});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string nm;
      logic [8:0]  ac;
      logic [31:0] an;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      ac = e.d ? c1 : c0;
      an = e.d ? n1 : n0;
      checks++;
      if (ac !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl: got %b want %b", nm, ac, e.ctl);
      end
      checks++;
      if (an !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_count: got %0d want %0d", nm, an, e.cnt);
      end
    end
  end
  initial begin
    @(posedge clk);
    #1;
    MEM_R_En = 1;
    chk(0, Z, 0, "reset_gated");
    rst = 0;
    chk(0, ST, 0, "mem_w1");
    chk(0, ST, 1, "mem_w2");
    chk(0, ST, 2, "mem_w3");
    chk(0, ST, 3, "mem_w4");
    chk(0, DN, 4, "mem_done");
    MEM_R_En = 0;
    chk(0, Z, 4, "idle");
    EXE_MEM_R_En = 1; EXE_WB_En = 1; EXE_dest = 5; ID_src1 = 5;
    chk(0, HZ, 4, "load_use");
    EXE_dest = 0;
    chk(0, Z, 5, "dest_mismatch");
    ID_src1 = 0;
    chk(0, Z, 5, "reg0_no_hazard");
    ID_src1 = 3; ID_src2 = 5; EXE_dest = 5; ID_two_src = 0;
    chk(0, Z, 5, "src2_unused");
    ID_two_src = 1;
    chk(0, HZ, 5, "src2_hazard");
    EXE_MEM_R_En = 0;
    chk(0, Z, 6, "forwarded");
    EXE_MEM_R_En = 1; Br_taken = 1;
    chk(0, BR, 6, "branch_over_hazard");
    Br_taken = 0; EXE_MEM_R_En = 0;
    chk(0, Z, 6, "clear");
    MEM_R_En = 1; Br_taken = 1; EXE_MEM_R_En = 1;
    chk(0, ST, 6, "mem_over_branch");
    MEM_R_En = 0; Br_taken = 0; EXE_MEM_R_En = 0;
    chk(0, ST, 7, "wait1");
    rst = 1;
    chk(0, Z, 8, "rst_in_wait");
    rst = 0;
    chk(0, Z, 0, "post_rst");
    MEM_W_En = 1;
    chk(0, ST, 0, "w_w1");
    chk(0, ST, 1, "w_w2");
    chk(0, ST, 2, "w_w3");
    chk(0, ST, 3, "w_w4");
    chk(0, DN, 4, "w_done");
    chk(0, ST, 4, "b2b_w1");
    MEM_W_En = 0;
    chk(0, ST, 5, "b2b_w2");
    chk(0, ST, 6, "b2b_w3");
    chk(0, ST, 7, "b2b_w4");
    chk(0, DN, 8, "b2b_done");
    chk(0, Z, 8, "b2b_idle");
    ID_src1 = 0; ID_src2 = 0; ID_two_src = 0; EXE_dest = 0; EXE_WB_En = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0; MEM_W_En = 1;
    chk(1, DN, 0, "w0_acc1");
    chk(1, DN, 0, "w0_acc2");
    chk(1, DN, 0, "w0_acc3");
    MEM_W_En = 0; MEM_WB_En = 1; MEM_dest = 7; ID_src1 = 7;
    chk(1, HZ, 0, "nofwd_mem_raw");
    MEM_WB_En = 0; EXE_WB_En = 1; EXE_dest = 7;
    chk(1, HZ, 1, "nofwd_exe_raw");
    ID_src1 = 8;
    chk(1, Z, 2, "nofwd_clear");
    ID_src1 = 7; MEM_W_En = 1;
    chk(1, HZ | DN, 2, "nofwd_done_and_hazard");
    MEM_W_En = 0; EXE_WB_En = 0;
    chk(1, Z, 3, "nofwd_idle");
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
